// File: rtl/approx_series_engine.sv
// approx_series_engine: sequential evaluator of truncated power series for
// exp(x), ln(1+x) and 1/(1-x). Each term takes three cycles: MUL_X -> SCALE -> ACC.
// Build option: define APPROX_SERIES_SAT_EN to clamp p/acc on overflow and
// report it on ovf_o. Without it, arithmetic wraps and ovf_o is tied to 0.
module approx_series_engine #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 14,
  parameter int OUT_W  = DATA_W + 4,
  parameter int NIT_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic        [NIT_W-1:0]  nit_i,
  input  logic        [1:0]        mode_i,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic signed [OUT_W-1:0]  y_o,
  output logic                     err_o,
  output logic                     ovf_o
);

  localparam int NMAX  = (1 << NIT_W) - 1;
  localparam int RCP_W = FRAC_W + 2;        // signed room for rcp(1) = 1.0
  localparam int PX_W  = OUT_W + DATA_W;
  localparam int PR_W  = OUT_W + RCP_W;
  localparam logic signed [OUT_W-1:0] ONE = OUT_W'(1 << FRAC_W);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL_X, S_SCALE, S_ACC, S_DONE} state_t;

  state_t                     state;
  logic signed [DATA_W-1:0]   x;
  logic        [NIT_W-1:0]    nit;
  logic        [NIT_W-1:0]    n;
  logic        [1:0]          mode;
  logic signed [OUT_W-1:0]    p;
  logic signed [OUT_W-1:0]    acc;
  logic signed [OUT_W-1:0]    c;

  logic signed [PX_W-1:0]     px_full;
  logic signed [PR_W-1:0]     pr_full;
  logic signed [OUT_W-1:0]    px_next;
  logic signed [OUT_W-1:0]    pr_res;
  logic signed [OUT_W-1:0]    acc_next;
  logic                       acc_sub;

`ifdef APPROX_SERIES_SAT_EN
  localparam logic signed [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  logic signed [PX_W-1:0]     px_wide;
  logic        [OUT_W:0]      acc_wide;
  logic                       px_hit;
  logic                       acc_hit;
  logic                       ovf_run;
`endif

  // Reciprocal table: rcp(n) = floor(1.0 / n); entry 0 is never addressed in SCALE.
  logic signed [RCP_W-1:0]    rcp_tab [0:NMAX];
  assign rcp_tab[0] = '0;
  genvar gi;
  generate
    for (gi = 1; gi <= NMAX; gi++) begin : g_rcp
      assign rcp_tab[gi] = RCP_W'((1 << FRAC_W) / gi);
    end
  endgenerate

  // Datapath: next p for MUL_X, scaled term for SCALE, next acc for ACC.
  always_comb begin
    px_full = PX_W'(p) * PX_W'(x);
    pr_full = PR_W'(p) * PR_W'(rcp_tab[n]);
    pr_res  = OUT_W'(pr_full >>> FRAC_W);
    // ln(1+x) alternates sign: even-numbered terms are subtracted.
    acc_sub = (mode == 2'd1) && !n[0];
`ifdef APPROX_SERIES_SAT_EN
    px_wide  = px_full >>> FRAC_W;
    px_hit   = !((&px_wide[PX_W-1:OUT_W-1]) || !(|px_wide[PX_W-1:OUT_W-1]));
    px_next  = px_hit ? (px_wide[PX_W-1] ? SAT_MIN : SAT_MAX) : px_wide[OUT_W-1:0];
    acc_wide = acc_sub ? ({acc[OUT_W-1], acc} - {c[OUT_W-1], c})
                       : ({acc[OUT_W-1], acc} + {c[OUT_W-1], c});
    acc_hit  = acc_wide[OUT_W] ^ acc_wide[OUT_W-1];
    acc_next = acc_hit ? (acc_wide[OUT_W] ? SAT_MIN : SAT_MAX) : acc_wide[OUT_W-1:0];
`else
    px_next  = OUT_W'(px_full >>> FRAC_W);
    acc_next = acc_sub ? (acc - c) : (acc + c);
`endif
  end

`ifndef APPROX_SERIES_SAT_EN
  assign ovf_o = 1'b0;
`endif

  // Control FSM with registered outputs; operands are latched once on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      y_o     <= '0;
      err_o   <= 1'b0;
      x       <= '0;
      nit     <= '0;
      mode    <= '0;
      n       <= '0;
      p       <= '0;
      acc     <= '0;
      c       <= '0;
`ifdef APPROX_SERIES_SAT_EN
      ovf_run <= 1'b0;
      ovf_o   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            x       <= x_i;
            nit     <= nit_i;
            mode    <= mode_i;
            valid_o <= 1'b0;
            busy_o  <= 1'b1;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          p   <= ONE;
          n   <= NIT_W'(1);
          acc <= (mode == 2'd1) ? '0 : ONE;
`ifdef APPROX_SERIES_SAT_EN
          ovf_run <= 1'b0;
`endif
          state <= (nit == '0 || mode == 2'd3) ? S_DONE : S_MUL_X;
        end
        S_MUL_X: begin
          p <= px_next;
`ifdef APPROX_SERIES_SAT_EN
          ovf_run <= ovf_run | px_hit;
`endif
          state <= S_SCALE;
        end
        S_SCALE: begin
          case (mode)
            2'd0: begin
              p <= pr_res;
              c <= pr_res;
            end
            2'd1:    c <= pr_res;
            default: c <= p;
          endcase
          state <= S_ACC;
        end
        S_ACC: begin
          acc <= acc_next;
`ifdef APPROX_SERIES_SAT_EN
          ovf_run <= ovf_run | acc_hit;
`endif
          if (n < nit) begin
            n     <= n + NIT_W'(1);
            state <= S_MUL_X;
          end else begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          y_o     <= (mode == 2'd3) ? '0 : acc;
          err_o   <= (mode == 2'd3);
          valid_o <= 1'b1;
          busy_o  <= 1'b0;
`ifdef APPROX_SERIES_SAT_EN
          ovf_o   <= ovf_run;
`endif
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_series_engine.sv
// Bench for approx_series_engine: directed cases plus randomized requests,
// each compared against a term-by-term arithmetic model of the series.
module tb_approx_series_engine;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 14;
  localparam int OUT_W  = 20;
  localparam int NIT_W  = 4;
  localparam longint ONE = longint'(1) << FRAC_W;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     start_i = 1'b0;
  logic signed [DATA_W-1:0] x_i = '0;
  logic        [NIT_W-1:0]  nit_i = '0;
  logic        [1:0]        mode_i = '0;
  logic                     busy_o;
  logic                     valid_o;
  logic signed [OUT_W-1:0]  y_o;
  logic                     err_o;
  logic                     ovf_o;

  int     errors = 0;
  int     checks = 0;
  longint obs_y;
  int     obs_lat;

  approx_series_engine #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W), .NIT_W(NIT_W)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .x_i(x_i), .nit_i(nit_i),
    .mode_i(mode_i), .busy_o(busy_o), .valid_o(valid_o), .y_o(y_o),
    .err_o(err_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bring a value into the OUT_W signed range: clamp or wrap depending on build.
  function automatic longint fit(input longint v, inout bit hit);
    longint lim;
    longint m;
    lim = longint'(1) << (OUT_W - 1);
`ifdef APPROX_SERIES_SAT_EN
    m = v;
    if (v > lim - 1) begin hit = 1'b1; m = lim - 1; end
    if (v < -lim)    begin hit = 1'b1; m = -lim;    end
`else
    m = v & ((lim << 1) - 1);
    if (m >= lim) m = m - (lim << 1);
`endif
    return m;
  endfunction

  // Series reference: term k multiplies by x, divides by k (exp/ln), then accumulates.
  task automatic model(input int mode, input longint x, input int nn,
                       output longint y, output bit err, output bit ovf, output int lat);
    longint p, acc, c, rcp;
    bit hit;
    hit = 1'b0;
    err = (mode == 3);
    lat = (nn == 0 || mode == 3) ? 2 : 3 * nn + 2;
    y   = 0;
    ovf = 1'b0;
    if (mode != 3) begin
      p   = ONE;
      acc = (mode == 1) ? 0 : ONE;
      for (int k = 1; k <= nn; k++) begin
        p   = fit((p * x) >>> FRAC_W, hit);
        rcp = ONE / k;
        if (mode == 0) begin
          p = (p * rcp) >>> FRAC_W;
          c = p;
        end else if (mode == 1) begin
          c = (p * rcp) >>> FRAC_W;
        end else begin
          c = p;
        end
        acc = fit((mode == 1 && k % 2 == 0) ? acc - c : acc + c, hit);
      end
      y   = acc;
      ovf = hit;
    end
  endtask

  // Issue one request starting now (called #1 after an edge) and check its result.
  task automatic run_req(input int mode, input longint x, input int nn,
                         input bit poke, input string tag);
    longint ey;
    bit     eerr, eovf, seen;
    int     elat, cyc;
    model(mode, x, nn, ey, eerr, eovf, elat);
    start_i = 1'b1;
    mode_i  = 2'(mode);
    x_i     = DATA_W'(x);
    nit_i   = NIT_W'(nn);
    @(posedge clk); #1;
    start_i = 1'b0;
    x_i     = DATA_W'($urandom);
    mode_i  = 2'($urandom);
    nit_i   = NIT_W'($urandom);
    check_value({tag, " busy_after_accept"}, busy_o, 1);
    check_value({tag, " valid_cleared"}, valid_o, 0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (valid_o) begin
        seen    = 1'b1;
        start_i = 1'b0;
      end else if (poke) begin
        start_i = 1'($urandom);
        x_i     = DATA_W'($urandom);
        mode_i  = 2'($urandom);
        nit_i   = NIT_W'($urandom);
      end
    end
    start_i = 1'b0;
    obs_y   = y_o;
    obs_lat = cyc;
    check_value({tag, " valid_seen"}, seen, 1);
    check_value({tag, " latency"}, cyc, elat);
    check_value({tag, " y"}, y_o, ey);
    check_value({tag, " err"}, err_o, eerr);
    check_value({tag, " ovf"}, ovf_o, eovf);
    check_value({tag, " busy_done"}, busy_o, 0);
    $display("txn %s mode=%0d x=%0d n=%0d y=%0d exp=%0d lat=%0d", tag, mode, x, nn, obs_y, ey, cyc);
  endtask

  initial begin
    longint xr;
    int     mr, nr;
    // Reset state.
    #1;
    check_value("rst busy", busy_o, 0);
    check_value("rst valid", valid_o, 0);
    check_value("rst y", y_o, 0);
    check_value("rst err", err_o, 0);
    check_value("rst ovf", ovf_o, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // First request goes in on the first edge after release.
    run_req(2, 8192, 3, 1'b0, "geo_half_n3");
    check_value("geo_half_n3 const_y", obs_y, 30720);
    check_value("geo_half_n3 const_lat", obs_lat, 11);

    // Hold: result stays while idle.
    repeat (3) @(posedge clk); #1;
    check_value("hold valid", valid_o, 1);
    check_value("hold y", y_o, 30720);

    run_req(0, 16384, 4, 1'b0, "exp_one_n4");
    check_value("exp_one_n4 const_y", obs_y, 44372);
    run_req(0, 0, 0, 1'b0, "exp_zero_n0");
    check_value("exp_zero_n0 const_y", obs_y, 16384);
    check_value("exp_zero_n0 const_lat", obs_lat, 2);
    run_req(1, 8192, 2, 1'b1, "ln_half_poked");
    check_value("ln_half_poked const_y", obs_y, 6144);
    run_req(3, longint'($signed(DATA_W'($urandom))), 5, 1'b0, "illegal_mode");
    check_value("illegal_mode const_y", obs_y, 0);
    check_value("illegal_mode const_lat", obs_lat, 2);
    run_req(2, 32767, 15, 1'b0, "geo_big_n15");
`ifdef APPROX_SERIES_SAT_EN
    check_value("geo_big_n15 sat_y", obs_y, 524287);
    check_value("geo_big_n15 sat_ovf", ovf_o, 1);
`else
    check_value("geo_big_n15 wrap_ovf", ovf_o, 0);
`endif

    // Randomized requests, back-to-back, some with ignored start pulses.
    for (int t = 0; t < 24; t++) begin
      xr = longint'($signed(DATA_W'($urandom)));
      if (t % 2 == 0) xr = xr >>> 1;
      mr = int'($urandom_range(0, 3));
      nr = int'($urandom_range(0, 15));
      run_req(mr, xr, nr, 1'($urandom), $sformatf("rnd%0d", t));
    end

    // Reset in the middle of an exp request.
    run_req(2, 8192, 3, 1'b0, "pre_reset");
    start_i = 1'b1;
    mode_i  = 2'd0;
    x_i     = DATA_W'(12000);
    nit_i   = NIT_W'(10);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_value("midrst busy", busy_o, 0);
    check_value("midrst valid", valid_o, 0);
    check_value("midrst y", y_o, 0);
    check_value("midrst err", err_o, 0);
    check_value("midrst ovf", ovf_o, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_value("midrst held_valid", valid_o, 0);
    end
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      check_value("midrst no_stale_valid", valid_o, 0);
    end
    run_req(0, 12000, 10, 1'b0, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
